fifo_ctrl_param: RTL and testbench
==================================

Name: fifo_ctrl_param

Overview:
Parametrised synchronous FIFO with integrated next-state FSM, storage, pointers and status flags. Successor to the fixed 8-deep, 3-bit-state FIFO controller. It adds:
- configurable width and depth;
- simultaneous read+write (WR_RD state);
- almost-full and almost-empty thresholds;
- per-request ack/error handshake outputs.

It sits between a producer and a consumer in the TOP datapath as the standard buffering block.

Parameters:
DATA_WIDTH, 32, data word width in bits
ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH (default 8 entries)
AF_LEVEL, 6, almost_full asserted when data_count >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserted when data_count <= AE_LEVEL

Ports:
clk  input  1  single clock, rising edge
reset_n  input  1  asynchronous active-low reset
wr_en  input  1  write request, sampled at rising clk
rd_en  input  1  read request, sampled at rising clk
din  input  DATA_WIDTH  write data, sampled with wr_en
dout  output  DATA_WIDTH  read data, registered
state  output  3  current FSM state
data_count  output  ADDR_WIDTH+1  number of stored words, 0..DEPTH
full  output  1  data_count == DEPTH
empty  output  1  data_count == 0
almost_full  output  1  data_count >= AF_LEVEL
almost_empty  output  1  data_count <= AE_LEVEL
wr_ack  output  1  write accepted at previous edge
wr_err  output  1  write refused (full) at previous edge
rd_ack  output  1  read accepted at previous edge; dout valid
rd_err  output  1  read refused (empty) at previous edge

Behaviour:
- Clock and reset are fixed: one clock `clk`; reset `reset_n` is asynchronous and active-low.
- Reset (reset_n=0, asynchronous):
  - state=IDLE, wr_ptr=rd_ptr=0, data_count=0, dout=0;
  - all ack/err outputs 0; empty=1, almost_empty=1, full=0, almost_full=0 (for AF_LEVEL>0).
  - Memory contents are not cleared.
  - Reset mid-operation aborts any in-flight request; no ack or err is issued for it.
- Decision rule: all decisions use wr_en, rd_en and the data_count value before the edge. Everything commits at that same edge: state, pointers, count, memory, dout, ack and err. ack/err are therefore 1-cycle pulses in the cycle after the request.
- Next-state / action, evaluated identically from every current state (no state-dependent lockout):
  - wr=0, rd=0 -> IDLE; no action.
  - wr=1, rd=0, count<DEPTH -> WRITE: mem[wr_ptr]<=din, wr_ptr+1, count+1, wr_ack.
  - wr=1, rd=0, count==DEPTH -> WR_ERROR: no change, wr_err.
  - wr=0, rd=1, count>0 -> READ: dout<=mem[rd_ptr], rd_ptr+1, count-1, rd_ack.
  - wr=0, rd=1, count==0 -> RD_ERROR: no change, dout holds, rd_err.
  - wr=1, rd=1, 0<count<DEPTH -> WR_RD: both operations, count unchanged, wr_ack and rd_ack.
  - wr=1, rd=1, count==0 -> WRITE: write only, wr_ack and rd_err. There is no fall-through; the read does not return din.
  - wr=1, rd=1, count==DEPTH -> READ: read only, rd_ack and wr_err. The write is refused even though a slot frees this cycle.
- State encoding (3 bits): IDLE 000, WRITE 001, READ 010, WR_ERROR 011, RD_ERROR 100, WR_RD 101. Codes 110/111 are illegal; if reached, go to IDLE at the next edge with no action.
- Pointers are ADDR_WIDTH bits and wrap modulo DEPTH without a special case.
- data_count is ADDR_WIDTH+1 bits. It is never allowed to exceed DEPTH or go below 0.
- Flags are combinational from the registered data_count, so they are valid in the same cycle as the count.
- dout holds its last read value except on an accepted read.

Decomposition:
- Package fifo_pkg:
  - 3-bit state type and the six state constants above;
  - DEPTH derivation function (2**ADDR_WIDTH).
- One sub-module, fifo_ns_param: purely combinational next-state plus action decode (wr_do, rd_do, wr_err_n, rd_err_n).
  - Inputs: wr_en, rd_en, state, data_count.
  - Parameter: ADDR_WIDTH.
- The top holds the state register, pointers, count, memory array and output registers.

Test Plan:
- Reset, then 8 writes of 0x11..0x88 (wr_en=1, 8 cycles) -> state WRITE, wr_ack each cycle, data_count 1..8, almost_full first at count=6, full=1 after 8th.
- 9th write with din=0x99 at full -> state WR_ERROR, wr_err=1 for one cycle, count stays 8, no ack.
- Then 8 reads -> dout 0x11..0x88 in order with rd_ack, count 8..0. A 9th read -> RD_ERROR, rd_err=1, dout stays 0x88, empty=1.
- Fill to count=4, then wr_en=rd_en=1 for 10 cycles -> state WR_RD, count stays 4, pointers wrap past 7->0, data order preserved.
- Simultaneous request at empty -> WRITE, wr_ack=1 and rd_err=1, count=1. Simultaneous at full -> READ, rd_ack=1 and wr_err=1, count=7.
- Assert reset_n=0 between clock edges during a WR_RD burst -> state, count and outputs clear immediately. After release, the first read gives RD_ERROR.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared state encoding and depth helper for the parametrised FIFO
package fifo_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        WRITE    = 3'b001,
        READ     = 3'b010,
        WR_ERROR = 3'b011,
        RD_ERROR = 3'b100,
        WR_RD    = 3'b101
    } state_t;

    function automatic int fifo_depth(input int addr_width);
        return 2 ** addr_width;
    endfunction

endpackage

// File: rtl/fifo_ns_param.sv
// fifo_ns_param: combinational next-state and action decode for the FIFO
module fifo_ns_param
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [2:0]            state,
    input  logic [ADDR_WIDTH:0]   data_count,
    output logic [2:0]            state_n,
    output logic                  wr_do,
    output logic                  rd_do,
    output logic                  wr_err_n,
    output logic                  rd_err_n
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(fifo_depth(ADDR_WIDTH));

    logic legal, is_full, is_empty;

    // Same decision from every legal state; illegal codes fall back to IDLE with no action
    always_comb begin
        legal    = state <= WR_RD;
        is_full  = data_count == DEPTH_C;
        is_empty = data_count == '0;
        wr_do    = legal && wr_en && !is_full;
        rd_do    = legal && rd_en && !is_empty;
        wr_err_n = legal && wr_en && is_full;
        rd_err_n = legal && rd_en && is_empty;
        state_n  = (wr_do && rd_do) ? WR_RD    :
                   wr_do            ? WRITE    :
                   rd_do            ? READ     :
                   wr_err_n         ? WR_ERROR :
                   rd_err_n         ? RD_ERROR : IDLE;
    end

endmodule

// File: rtl/fifo_ctrl_param.sv
// fifo_ctrl_param: parametrised synchronous FIFO with state, flags and ack/err handshakes
module fifo_ctrl_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [2:0]            state,
    output logic [ADDR_WIDTH:0]   data_count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic                  rd_ack,
    output logic                  rd_err
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] dout_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [2:0]            state_q, state_d;
    logic                  wr_do, rd_do, wr_err_d, rd_err_d;
    logic                  wr_ack_q, wr_err_q, rd_ack_q, rd_err_q;

    fifo_ns_param #(.ADDR_WIDTH(ADDR_WIDTH)) u_ns (
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .state      (state_q),
        .data_count (count_q),
        .state_n    (state_d),
        .wr_do      (wr_do),
        .rd_do      (rd_do),
        .wr_err_n   (wr_err_d),
        .rd_err_n   (rd_err_d)
    );

    // Count moves only when exactly one side is accepted
    always_comb begin
        count_d = (wr_do && !rd_do) ? count_q + 1'b1 :
                  (rd_do && !wr_do) ? count_q - 1'b1 : count_q;
    end

    // Storage is not reset; contents survive reset by design
    always_ff @(posedge clk) begin
        if (wr_do) mem[wr_ptr_q] <= din;
    end

    // State, pointers, count, read data and handshake pulses all commit at the same edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
            rd_ack_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ack_q <= wr_do;
            wr_err_q <= wr_err_d;
            rd_ack_q <= rd_do;
            rd_err_q <= rd_err_d;
            if (wr_do) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_do) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                dout_q   <= mem[rd_ptr_q];
            end
        end
    end

    assign dout         = dout_q;
    assign state        = state_q;
    assign data_count   = count_q;
    assign full         = count_q == DEPTH_C;
    assign empty        = count_q == '0;
    assign almost_full  = count_q >= AF_C;
    assign almost_empty = count_q <= AE_C;
    assign wr_ack       = wr_ack_q;
    assign wr_err       = wr_err_q;
    assign rd_ack       = rd_ack_q;
    assign rd_err       = rd_err_q;

endmodule

// File: tb/tb_fifo_ctrl_param.sv
// tb_fifo_ctrl_param: directed self-checking bench for the parametrised FIFO
module tb_fifo_ctrl_param;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic [2:0]  state;
    logic [3:0]  data_count;
    logic        full, empty, almost_full, almost_empty;
    logic        wr_ack, wr_err, rd_ack, rd_err;
    int          n_cmp = 0;
    int          n_err = 0;

    fifo_ctrl_param dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .din          (din),
        .dout         (dout),
        .state        (state),
        .data_count   (data_count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .wr_ack       (wr_ack),
        .wr_err       (wr_err),
        .rd_ack       (rd_ack),
        .rd_err       (rd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic w, input logic r, input logic [31:0] d);
        @(negedge clk);
        wr_en = w;
        rd_en = r;
        din   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_st(input string tag, input logic [2:0] st, input int cnt,
                          input logic wa, input logic we, input logic ra, input logic re);
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".count"}, 32'(data_count), 32'(cnt));
        chk({tag, ".full"}, 32'(full), 32'(cnt == 8));
        chk({tag, ".empty"}, 32'(empty), 32'(cnt == 0));
        chk({tag, ".afull"}, 32'(almost_full), 32'(cnt >= 6));
        chk({tag, ".aempty"}, 32'(almost_empty), 32'(cnt <= 2));
        chk({tag, ".wr_ack"}, 32'(wr_ack), 32'(wa));
        chk({tag, ".wr_err"}, 32'(wr_err), 32'(we));
        chk({tag, ".rd_ack"}, 32'(rd_ack), 32'(ra));
        chk({tag, ".rd_err"}, 32'(rd_err), 32'(re));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk_st("reset", 3'd0, 0, 0, 0, 0, 0);
        chk("reset.dout", dout, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 1; i <= 8; i++) begin
            step(1, 0, 32'h11 * i);
            chk_st($sformatf("wr%0d", i), 3'd1, i, 1, 0, 0, 0);
        end
        step(1, 0, 32'h99);
        chk_st("wr_full", 3'd3, 8, 0, 1, 0, 0);

        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 32'h0);
            chk_st($sformatf("rd%0d", i), 3'd2, 8 - i, 0, 0, 1, 0);
            chk($sformatf("rd%0d.dout", i), dout, 32'h11 * i);
        end
        step(0, 1, 32'h0);
        chk_st("rd_empty", 3'd4, 0, 0, 0, 0, 1);
        chk("rd_empty.dout", dout, 32'h88);

        for (int i = 0; i < 4; i++) begin
            step(1, 0, 32'hA0 + i);
            chk_st($sformatf("fill%0d", i), 3'd1, i + 1, 1, 0, 0, 0);
        end
        for (int k = 0; k < 10; k++) begin
            step(1, 1, 32'hB0 + k);
            chk_st($sformatf("wrrd%0d", k), 3'd5, 4, 1, 0, 1, 0);
            chk($sformatf("wrrd%0d.dout", k), dout, (k < 4) ? 32'hA0 + k : 32'hB0 + k - 4);
        end
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 32'h0);
            chk_st($sformatf("drain%0d", k), 3'd2, 3 - k, 0, 0, 1, 0);
            chk($sformatf("drain%0d.dout", k), dout, 32'hB6 + k);
        end

        step(1, 1, 32'hC0);
        chk_st("both_empty", 3'd1, 1, 1, 0, 0, 1);
        chk("both_empty.dout", dout, 32'hB9);
        for (int i = 1; i < 8; i++) step(1, 0, 32'hC0 + i);
        chk_st("refill", 3'd1, 8, 1, 0, 0, 0);
        step(1, 1, 32'hDD);
        chk_st("both_full", 3'd2, 7, 0, 1, 1, 0);
        chk("both_full.dout", dout, 32'hC0);

        step(1, 1, 32'hE0);
        chk_st("burst", 3'd5, 7, 1, 0, 1, 0);
        chk("burst.dout", dout, 32'hC1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk_st("async_rst", 3'd0, 0, 0, 0, 0, 0);
        chk("async_rst.dout", dout, 32'h0);
        @(posedge clk);
        #1;
        chk_st("rst_held", 3'd0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        step(0, 1, 32'h0);
        chk_st("post_rst_rd", 3'd4, 0, 0, 0, 0, 1);
        chk("post_rst_rd.dout", dout, 32'h0);
        step(0, 0, 32'h0);
        chk_st("idle", 3'd0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
